// File: rtl/imm_encode.sv
// Purpose : inverse immediate extender; turns a 32-bit value + ImmSrc mode into Extend_in[23:0].
// Latency : 1 cycle for modes 01/10/11; mode 00 r+2 (hit at rot r) or MAX_ROT+2 (no hit).
// Backpr. : none queued; start is only sampled in IDLE, ignored while busy.
//
// Ports   : clk, reset_n (async, active-low)
//           start, mode[1:0], value[31:0]        request (mode 00 rot imm8, 01 imm12, 10 branch, 11 rsvd)
//           busy, done (1-cycle pulse)           status
//           valid, field[23:0], rot[3:0]         registered result, held until the next result
// Option  : IMM_ENCODE_FAST_EN checks every rotation in the accepting cycle (mode 00 becomes 1 cycle).
module imm_encode #(
    parameter int MAX_ROT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [23:0] field,
    output logic [3:0]  rot
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        accept;
    logic        dir_valid;
    logic [23:0] dir_field;

    assign accept = (state_q == S_IDLE) && start;

    // Rotate left by twice the rotation index; a shift by 32 yields zero, so r=0 is a plain copy.
    function automatic logic [31:0] rotl2(input logic [31:0] v, input logic [3:0] r);
        logic [4:0] sh;
        sh = {r, 1'b0};
        return (v << sh) | (v >> (6'd32 - {1'b0, sh}));
    endfunction

    // Modes that need no search are resolved straight from the request inputs.
    always_comb begin
        dir_valid = 1'b0;
        dir_field = '0;
        case (mode)
            2'b01: begin
                dir_valid = (value[31:12] == 20'd0);
                dir_field = dir_valid ? {12'd0, value[11:0]} : 24'd0;
            end
            2'b10: begin
                // Word aligned and representable as a 26-bit signed byte offset.
                dir_valid = (value[1:0] == 2'b00) && (value[31:25] == {7{value[25]}});
                dir_field = dir_valid ? value[25:2] : 24'd0;
            end
            default: begin
                dir_valid = 1'b0;
                dir_field = '0;
            end
        endcase
    end

`ifdef IMM_ENCODE_FAST_EN
    localparam logic [3:0] LAST_ROT = 4'(MAX_ROT);

    logic       fast_hit;
    logic [3:0] fast_rot;
    logic [7:0] fast_lo;

    // Walk from the top down so the lowest matching rotation is the one left standing.
    always_comb begin
        logic [31:0] tmp;
        tmp      = '0;
        fast_hit = 1'b0;
        fast_rot = '0;
        fast_lo  = '0;
        for (int r = 15; r >= 0; r--) begin
            tmp = rotl2(value, 4'(r));
            if ((4'(r) <= LAST_ROT) && (tmp[31:8] == 24'd0)) begin
                fast_hit = 1'b1;
                fast_rot = 4'(r);
                fast_lo  = tmp[7:0];
            end
        end
    end
`else
    localparam logic [3:0] LAST_ROT = 4'(MAX_ROT);

    logic [31:0] val_q;
    logic [3:0]  cnt_q;
    logic [31:0] srch_t;
    logic        srch_hit;
    logic        srch_last;

    assign srch_t    = rotl2(val_q, cnt_q);
    assign srch_hit  = (srch_t[31:8] == 24'd0);
    assign srch_last = (cnt_q == LAST_ROT);
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef IMM_ENCODE_FAST_EN
                    state_d = S_DONE;
`else
                    state_d = (mode == 2'b00) ? S_SEARCH : S_DONE;
`endif
                end
            end
            S_SEARCH: begin
`ifndef IMM_ENCODE_FAST_EN
                if (srch_hit || srch_last) begin
                    state_d = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Result registers only move on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            field <= '0;
            rot   <= '0;
`ifndef IMM_ENCODE_FAST_EN
            val_q <= '0;
            cnt_q <= '0;
`endif
        end else if (accept) begin
            if (mode != 2'b00) begin
                valid <= dir_valid;
                field <= dir_field;
                rot   <= '0;
            end else begin
`ifdef IMM_ENCODE_FAST_EN
                valid <= fast_hit;
                field <= fast_hit ? {12'd0, fast_rot, fast_lo} : 24'd0;
                rot   <= fast_hit ? fast_rot : 4'd0;
`endif
            end
`ifndef IMM_ENCODE_FAST_EN
            val_q <= value;
            cnt_q <= '0;
`endif
        end
`ifndef IMM_ENCODE_FAST_EN
        else if (state_q == S_SEARCH) begin
            if (srch_hit) begin
                valid <= 1'b1;
                rot   <= cnt_q;
                field <= {12'd0, cnt_q, srch_t[7:0]};
            end else if (srch_last) begin
                valid <= 1'b0;
                field <= '0;
                rot   <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_imm_encode.sv
// Purpose : randomized + directed scoreboard bench for imm_encode.
// Latency : expected done latency is carried per request and compared on each done pulse.
// Backpr. : requests are only issued while busy=0, except deliberate ignored-start pulses.
module tb_imm_encode;

    localparam int MAX_ROT = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] value = 32'd0;
    logic        busy;
    logic        done;
    logic        valid;
    logic [23:0] field;
    logic [3:0]  rot;

    always #5 clk = ~clk;

    imm_encode #(.MAX_ROT(MAX_ROT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .mode    (mode),
        .value   (value),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .field   (field),
        .rot     (rot)
    );

    typedef struct {
        logic        v;
        logic [23:0] f;
        logic [3:0]  r;
        int          lat;
        int          acc;
        logic [1:0]  m;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: search rotations with plain arithmetic, range checks with signed compares.
    function automatic exp_t model(input logic [1:0] m, input logic [31:0] v);
        exp_t e;
        int   sv;
        e.v = 1'b0; e.f = '0; e.r = '0; e.acc = 0; e.m = m; e.val = v;
        e.lat = 1;
        case (m)
            2'b00: begin
                e.lat = MAX_ROT + 2;
                for (int r = 0; r <= MAX_ROT; r++) begin
                    logic [31:0] t;
                    int s;
                    s = 2 * r;
                    t = (s == 0) ? v : ((v << s) | (v >> (32 - s)));
                    if (t < 32'd256) begin
                        e.v   = 1'b1;
                        e.r   = 4'(r);
                        e.f   = 24'(r * 256 + int'(t));
                        e.lat = r + 2;
                        break;
                    end
                end
`ifdef IMM_ENCODE_FAST_EN
                e.lat = 1;
`endif
            end
            2'b01: begin
                e.v = (v < 32'h1000);
                e.f = e.v ? 24'(v) : 24'd0;
            end
            2'b10: begin
                sv  = $signed(v);
                e.v = ((v % 4) == 0) && (sv >= -33554432) && (sv <= 33554431);
                e.f = e.v ? 24'(sv / 4) : 24'd0;
            end
            default: e.v = 1'b0;
        endcase
        return e;
    endfunction

    // Issue one request at a negedge once the DUT is idle; push its expectation at the accept edge.
    task automatic issue(input logic [1:0] m, input logic [31:0] v);
        exp_t e;
        int   n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
            return;
        end
        mode  = m;
        value = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        e     = model(m, v);
        e.acc = cyc;
        sbq.push_back(e);
        start = 1'b0;
        mode  = 2'($urandom);
        value = $urandom;
        @(negedge clk);
    endtask

    // Monitor: pops on each done pulse, otherwise checks that results are held.
    initial begin
        exp_t        e;
        logic        prev_done;
        logic        last_v;
        logic [23:0] last_f;
        logic [3:0]  last_r;
        prev_done = 1'b0; last_v = 1'b0; last_f = '0; last_r = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_done = 1'b0; last_v = 1'b0; last_f = '0; last_r = '0;
            end else begin
                if (done) begin
                    chk("done_single_cycle", 32'(prev_done), 32'd0);
                    chk("busy_in_done", 32'(busy), 32'd1);
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done=1 with no request outstanding");
                    end else begin
                        e = sbq.pop_front();
                        chk($sformatf("valid m%0d v%08h", e.m, e.val), 32'(valid), 32'(e.v));
                        chk($sformatf("field m%0d v%08h", e.m, e.val), 32'(field), 32'(e.f));
                        chk($sformatf("rot m%0d v%08h", e.m, e.val), 32'(rot), 32'(e.r));
                        chk($sformatf("latency m%0d v%08h", e.m, e.val), 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                    last_v = valid; last_f = field; last_r = rot;
                end else begin
                    chk("result_held", {7'd0, valid, field}, {7'd0, last_v, last_f});
                    chk("rot_held", 32'(rot), 32'(last_r));
                end
                prev_done = done;
            end
        end
    end

    function automatic logic [31:0] rand_value(input logic [1:0] m);
        logic [31:0] x;
        int          s;
        x = $urandom;
        case ($urandom_range(0, 3))
            0: return x;
            1: return x & 32'h0000_1FFF;
            2: begin
                s = 2 * $urandom_range(0, 15);
                x = x & 32'hFF;
                return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
            end
            default: begin
                if (m == 2'b10) return {{7{x[25]}}, x[24:2], 2'b00};
                return x & 32'h0000_0FFF;
            end
        endcase
    endfunction

    initial begin
        int n;
        // Reset state
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", {7'd0, valid, field}, 32'd0);
        chk("reset_rot", 32'(rot), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(2'b00, 32'h0000_00FF);
        issue(2'b00, 32'hFF00_0000);
        issue(2'b00, 32'hF000_000F);
        issue(2'b00, 32'h0000_0101);
        issue(2'b00, 32'h0000_0000);
        issue(2'b10, 32'hFFFF_FFF8);
        issue(2'b10, 32'h0000_0006);
        issue(2'b10, 32'h0200_0000);
        issue(2'b10, 32'h01FF_FFFC);
        issue(2'b01, 32'h0000_0ABC);
        issue(2'b01, 32'h0000_1000);
        issue(2'b11, 32'h0000_0012);

        // Start held high: accepted in IDLE, ignored in the DONE cycle, accepted again after.
        while (busy) @(negedge clk);
        begin
            exp_t e;
            mode = 2'b01; value = 32'h0000_0ABC; start = 1'b1;
            @(posedge clk); #1;
            e = model(2'b01, 32'h0000_0ABC); e.acc = cyc; sbq.push_back(e);
            value = 32'h0000_0123;
            @(posedge clk);
            @(posedge clk); #1;
            e = model(2'b01, 32'h0000_0123); e.acc = cyc; sbq.push_back(e);
            start = 1'b0;
            @(negedge clk);
        end

`ifndef IMM_ENCODE_FAST_EN
        // Starts pulsed during SEARCH are dropped.
        issue(2'b00, 32'h0000_0101);
        repeat (3) begin
            start = 1'b1; mode = 2'b01; value = 32'h0000_0005;
            @(negedge clk);
        end
        start = 1'b0;
        issue(2'b00, 32'h3FC0_0000);
`endif

        // Reset mid-search: everything clears at once, no done follows.
        issue(2'b00, 32'h0000_0101);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_result", {7'd0, valid, field}, 32'd0);
        chk("midreset_rot", 32'(rot), 32'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(2'b00, 32'hFF00_0000);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [1:0] m;
            m = 2'($urandom_range(0, 3));
            issue(m, rand_value(m));
        end

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
